// File: rtl/seg7_scan_decoder_if.sv
// Display-bus bundle for the 7-segment scan decoder: the multiplexed segment
// bus as seen on the board, plus the decoded frame read back from it.
interface seg7_scan_decoder_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      sample_en;
    logic [6:0]                seg_in;
    logic [NUM_DIGITS-1:0]     dig_sel;
    logic [4*NUM_DIGITS-1:0]   bcd_out;
    logic [NUM_DIGITS-1:0]     blank_mask;
    logic                      frame_valid;
    logic                      err_pattern;

    // Display-driver side: drives the scan bus, observes the decoded frame.
    modport master (
        output sample_en, seg_in, dig_sel,
        input  bcd_out, blank_mask, frame_valid, err_pattern
    );

    // Decoder side: samples the scan bus, publishes the decoded frame.
    modport slave (
        input  sample_en, seg_in, dig_sel,
        output bcd_out, blank_mask, frame_valid, err_pattern
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Samples a time-multiplexed 7-segment bus, deglitches each {digit, pattern}
// pair over STABLE_CNT identical samples, decodes it back to BCD and publishes
// a full multi-digit frame with a one-cycle frame_valid pulse.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    seg7_scan_decoder_if.slave  disp
);

    localparam int         KEY_W      = NUM_DIGITS + 7;
    localparam logic [3:0] STABLE_LIM = 4'(STABLE_CNT);

    typedef enum logic [1:0] {S_WAIT, S_COUNT, S_HELD} state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic [KEY_W-1:0]        key_q;

    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   shadow_blank_q, shadow_blank_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic [4*NUM_DIGITS-1:0] bcd_q;
    logic [NUM_DIGITS-1:0]   blank_q;
    logic                    frame_valid_q;
    logic                    err_q;

    logic [KEY_W-1:0]        key_in;
    logic                    qual;
    logic                    same;
    logic [3:0]              cnt_inc;
    logic                    commit;
    logic [5:0]              dec;
    logic                    err_d;
    logic                    frame_done;

    // Pattern decode: result is {legal, blank, bcd}; blank digits read as 4'hF.
    function automatic logic [5:0] decode_seg(input logic [6:0] seg);
        logic [5:0] r;
        case (seg)
            7'b1111110: r = {2'b10, 4'd0};
            7'b0110000: r = {2'b10, 4'd1};
            7'b1101101: r = {2'b10, 4'd2};
            7'b1111001: r = {2'b10, 4'd3};
            7'b0110011: r = {2'b10, 4'd4};
            7'b1011011: r = {2'b10, 4'd5};
            7'b1011111: r = {2'b10, 4'd6};
            7'b1110000: r = {2'b10, 4'd7};
            7'b1111111: r = {2'b10, 4'd8};
            7'b1111011: r = {2'b10, 4'd9};
            7'b0000000: r = {2'b11, 4'hF};
            default:    r = {2'b00, 4'h0};
        endcase
        return r;
    endfunction

    // Commit decision and next shadow/seen contents for the current sample.
    always_comb begin
        key_in         = {disp.dig_sel, disp.seg_in};
        qual           = disp.sample_en && ($countones(disp.dig_sel) == 1);
        same           = (key_in == key_q);
        cnt_inc        = cnt_q + 4'd1;
        commit         = 1'b0;
        if (qual) begin
            if (state_q == S_WAIT || !same)
                commit = (STABLE_LIM == 4'd1);
            else if (state_q == S_COUNT)
                commit = (cnt_inc == STABLE_LIM);
        end
        dec            = decode_seg(disp.seg_in);
        err_d          = commit && !dec[5];
        shadow_d       = shadow_q;
        shadow_blank_d = shadow_blank_q;
        seen_d         = seen_q;
        if (commit && dec[5]) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (disp.dig_sel[i]) begin
                    shadow_d[4*i +: 4] = dec[3:0];
                    shadow_blank_d[i]  = dec[4];
                    seen_d[i]          = 1'b1;
                end
            end
        end
        frame_done = commit && dec[5] && (seen_d == '1);
    end

    // Stability filter: tracks the current key and how many times it repeated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT;
            cnt_q   <= 4'd0;
            key_q   <= '0;
        end else if (disp.sample_en) begin
            if (!qual) begin
                state_q <= S_WAIT;
                cnt_q   <= 4'd0;
            end else if (state_q == S_WAIT || !same) begin
                key_q   <= key_in;
                cnt_q   <= 4'd1;
                state_q <= (STABLE_LIM == 4'd1) ? S_HELD : S_COUNT;
            end else if (state_q == S_COUNT) begin
                cnt_q <= cnt_inc;
                if (cnt_inc == STABLE_LIM)
                    state_q <= S_HELD;
            end
        end
    end

    // Frame assembly: shadow accumulates commits, published once every digit is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q       <= '0;
            shadow_blank_q <= '0;
            seen_q         <= '0;
            bcd_q          <= '0;
            blank_q        <= '0;
            frame_valid_q  <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            shadow_q       <= shadow_d;
            shadow_blank_q <= shadow_blank_d;
            seen_q         <= frame_done ? '0 : seen_d;
            frame_valid_q  <= frame_done;
            err_q          <= err_d;
            if (frame_done) begin
                bcd_q   <= shadow_d;
                blank_q <= shadow_blank_d;
            end
        end
    end

    assign disp.bcd_out     = bcd_q;
    assign disp.blank_mask  = blank_q;
    assign disp.frame_valid = frame_valid_q;
    assign disp.err_pattern = err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: a 4-digit/3-sample instance and a
// 1-digit/1-sample instance share the clock and have independent resets.
module tb_seg7_scan_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n = 1'b1;
    logic rst_b_n = 1'b1;

    seg7_scan_decoder_if #(.NUM_DIGITS(4)) ifa ();
    seg7_scan_decoder_if #(.NUM_DIGITS(1)) ifb ();

    seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CNT(3)) dut_a (
        .clk   (clk),
        .rst_n (rst_a_n),
        .disp  (ifa)
    );

    seg7_scan_decoder #(.NUM_DIGITS(1), .STABLE_CNT(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_b_n),
        .disp  (ifb)
    );

    int nerr = 0;
    int nchk = 0;
    int fv_a = 0, err_a = 0, fv_b = 0, err_b = 0;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_ILL   = 7'b1000000;

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] s;
        case (d)
            0: s = 7'b1111110;
            1: s = 7'b0110000;
            2: s = 7'b1101101;
            3: s = 7'b1111001;
            4: s = 7'b0110011;
            5: s = 7'b1011011;
            6: s = 7'b1011111;
            7: s = 7'b1110000;
            8: s = 7'b1111111;
            9: s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // One clock; outputs are sampled 1 time unit after the edge and pulses tallied.
    task automatic tick();
        @(posedge clk);
        #1;
        fv_a  += int'(ifa.frame_valid);
        err_a += int'(ifa.err_pattern);
        fv_b  += int'(ifb.frame_valid);
        err_b += int'(ifb.err_pattern);
    endtask

    task automatic drive_a(input logic en, input logic [3:0] sel, input logic [6:0] seg, input int n);
        for (int k = 0; k < n; k++) begin
            ifa.sample_en = en;
            ifa.dig_sel   = sel;
            ifa.seg_in    = seg;
            tick();
        end
    endtask

    task automatic drive_b(input logic en, input logic sel, input logic [6:0] seg);
        ifb.sample_en = en;
        ifb.dig_sel   = sel;
        ifb.seg_in    = seg;
        tick();
    endtask

    task automatic scan_upper(input int d3, input int d2, input int d1);
        drive_a(1'b1, 4'b1000, seg_of(d3), 3);
        drive_a(1'b1, 4'b0100, seg_of(d2), 3);
        drive_a(1'b1, 4'b0010, seg_of(d1), 3);
    endtask

    task automatic test_reset();
        int b;
        ifa.sample_en = 1'b0; ifa.dig_sel = 4'b0000; ifa.seg_in = 7'd0;
        ifb.sample_en = 1'b0; ifb.dig_sel = 1'b0;    ifb.seg_in = 7'd0;
        #2;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ifa.sample_en = 1'($urandom); ifa.dig_sel = 4'($urandom); ifa.seg_in = 7'($urandom);
            ifb.sample_en = 1'($urandom); ifb.dig_sel = 1'($urandom); ifb.seg_in = 7'($urandom);
            tick();
        end
        nchk++; if (ifa.bcd_out !== 16'h0000) begin nerr++; $display("FAIL reset_a_bcd: got %h want 0000", ifa.bcd_out); end
        nchk++; if (ifa.blank_mask !== 4'b0000) begin nerr++; $display("FAIL reset_a_blank: got %b want 0000", ifa.blank_mask); end
        nchk++; if (ifa.frame_valid !== 1'b0) begin nerr++; $display("FAIL reset_a_fv: got %b want 0", ifa.frame_valid); end
        nchk++; if (ifa.err_pattern !== 1'b0) begin nerr++; $display("FAIL reset_a_err: got %b want 0", ifa.err_pattern); end
        nchk++; if (ifb.bcd_out !== 4'h0 || ifb.blank_mask !== 1'b0) begin nerr++; $display("FAIL reset_b_data: got %h/%b want 0/0", ifb.bcd_out, ifb.blank_mask); end
        nchk++; if (ifb.frame_valid !== 1'b0 || ifb.err_pattern !== 1'b0) begin nerr++; $display("FAIL reset_b_pulses: got %b/%b want 0/0", ifb.frame_valid, ifb.err_pattern); end
        ifa.sample_en = 1'b0;
        ifb.sample_en = 1'b0;
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        tick();
        b = fv_a;
        drive_a(1'b1, 4'b1000, seg_of(1), 3);
        drive_a(1'b1, 4'b0100, seg_of(2), 3);
        drive_a(1'b1, 4'b0010, seg_of(3), 3);
        drive_a(1'b1, 4'b0001, seg_of(4), 3);
        nchk++; if (ifa.frame_valid !== 1'b1) begin nerr++; $display("FAIL first_frame_fv: got %b want 1", ifa.frame_valid); end
        nchk++; if (fv_a - b != 1) begin nerr++; $display("FAIL first_frame_count: got %0d want 1", fv_a - b); end
        nchk++; if (ifa.bcd_out !== 16'h1234) begin nerr++; $display("FAIL first_frame_bcd: got %h want 1234", ifa.bcd_out); end
        nchk++; if (ifa.blank_mask !== 4'b0000) begin nerr++; $display("FAIL first_frame_blank: got %b want 0000", ifa.blank_mask); end
        drive_a(1'b0, 4'b0000, 7'd0, 1);
        nchk++; if (ifa.frame_valid !== 1'b0) begin nerr++; $display("FAIL fv_one_cycle: got %b want 0", ifa.frame_valid); end
        nchk++; if (ifa.bcd_out !== 16'h1234) begin nerr++; $display("FAIL frame_hold: got %h want 1234", ifa.bcd_out); end
    endtask

    task automatic test_glitch();
        int b;
        b = fv_a;
        scan_upper(8, 6, 0);
        drive_a(1'b1, 4'b0001, seg_of(5), 2);
        drive_a(1'b1, 4'b0001, seg_of(8), 1);
        drive_a(1'b1, 4'b0001, seg_of(7), 2);
        nchk++; if (fv_a != b) begin nerr++; $display("FAIL glitch_early_commit: frames %0d want 0", fv_a - b); end
        drive_a(1'b1, 4'b0001, seg_of(7), 1);
        nchk++; if (ifa.frame_valid !== 1'b1 || fv_a - b != 1) begin nerr++; $display("FAIL glitch_commit: fv %b frames %0d want 1/1", ifa.frame_valid, fv_a - b); end
        nchk++; if (ifa.bcd_out !== 16'h8607) begin nerr++; $display("FAIL glitch_bcd: got %h want 8607", ifa.bcd_out); end
    endtask

    task automatic test_blank_illegal();
        int b, e;
        b = fv_a;
        e = err_a;
        drive_a(1'b1, 4'b1000, seg_of(2), 3);
        drive_a(1'b1, 4'b0100, SEG_BLANK, 3);
        drive_a(1'b1, 4'b0010, SEG_ILL, 3);
        nchk++; if (ifa.err_pattern !== 1'b1) begin nerr++; $display("FAIL illegal_err_pulse: got %b want 1", ifa.err_pattern); end
        drive_a(1'b1, 4'b0001, seg_of(9), 3);
        nchk++; if (ifa.err_pattern !== 1'b0 || err_a - e != 1) begin nerr++; $display("FAIL illegal_err_count: now %b count %0d want 0/1", ifa.err_pattern, err_a - e); end
        nchk++; if (fv_a != b) begin nerr++; $display("FAIL illegal_no_frame: frames %0d want 0", fv_a - b); end
        drive_a(1'b1, 4'b0010, seg_of(7), 3);
        nchk++; if (ifa.frame_valid !== 1'b1 || fv_a - b != 1) begin nerr++; $display("FAIL blank_frame_fv: fv %b frames %0d want 1/1", ifa.frame_valid, fv_a - b); end
        nchk++; if (ifa.bcd_out !== 16'h2F79) begin nerr++; $display("FAIL blank_frame_bcd: got %h want 2f79", ifa.bcd_out); end
        nchk++; if (ifa.blank_mask !== 4'b0100) begin nerr++; $display("FAIL blank_frame_mask: got %b want 0100", ifa.blank_mask); end
    endtask

    task automatic test_select_errors();
        int b;
        b = fv_a;
        scan_upper(1, 1, 1);
        drive_a(1'b1, 4'b0001, seg_of(3), 2);
        drive_a(1'b1, 4'b0000, seg_of(3), 1);
        drive_a(1'b1, 4'b0001, seg_of(3), 2);
        nchk++; if (fv_a != b) begin nerr++; $display("FAIL sel_zero_restart: frames %0d want 0", fv_a - b); end
        drive_a(1'b1, 4'b0001, seg_of(3), 1);
        nchk++; if (ifa.frame_valid !== 1'b1 || ifa.bcd_out !== 16'h1113) begin nerr++; $display("FAIL sel_zero_frame: fv %b bcd %h want 1/1113", ifa.frame_valid, ifa.bcd_out); end
        b = fv_a;
        scan_upper(4, 4, 4);
        drive_a(1'b1, 4'b0001, seg_of(5), 1);
        drive_a(1'b1, 4'b0110, seg_of(5), 1);
        drive_a(1'b1, 4'b0001, seg_of(5), 2);
        nchk++; if (fv_a != b) begin nerr++; $display("FAIL sel_multi_restart: frames %0d want 0", fv_a - b); end
        drive_a(1'b1, 4'b0001, seg_of(5), 1);
        nchk++; if (ifa.frame_valid !== 1'b1 || ifa.bcd_out !== 16'h4445) begin nerr++; $display("FAIL sel_multi_frame: fv %b bcd %h want 1/4445", ifa.frame_valid, ifa.bcd_out); end
        b = fv_a;
        scan_upper(7, 8, 9);
        drive_a(1'b1, 4'b0001, seg_of(6), 1);
        drive_a(1'b0, 4'b0000, SEG_ILL, 1);
        drive_a(1'b1, 4'b0001, seg_of(6), 1);
        drive_a(1'b0, 4'b0110, SEG_BLANK, 2);
        nchk++; if (fv_a != b) begin nerr++; $display("FAIL gap_early: frames %0d want 0", fv_a - b); end
        drive_a(1'b1, 4'b0001, seg_of(6), 1);
        nchk++; if (ifa.frame_valid !== 1'b1 || ifa.bcd_out !== 16'h7896) begin nerr++; $display("FAIL gap_frame: fv %b bcd %h want 1/7896", ifa.frame_valid, ifa.bcd_out); end
    endtask

    task automatic test_hold_overwrite();
        int b;
        b = fv_a;
        scan_upper(1, 1, 1);
        drive_a(1'b1, 4'b0001, seg_of(9), 10);
        nchk++; if (fv_a - b != 1 || ifa.bcd_out !== 16'h1119) begin nerr++; $display("FAIL hold_frame: frames %0d bcd %h want 1/1119", fv_a - b, ifa.bcd_out); end
        b = fv_a;
        scan_upper(2, 2, 2);
        nchk++; if (fv_a != b) begin nerr++; $display("FAIL hold_single_commit: frames %0d want 0", fv_a - b); end
        drive_a(1'b1, 4'b0001, seg_of(6), 3);
        nchk++; if (fv_a - b != 1 || ifa.bcd_out !== 16'h2226) begin nerr++; $display("FAIL hold_next_frame: frames %0d bcd %h want 1/2226", fv_a - b, ifa.bcd_out); end
        b = fv_a;
        drive_a(1'b1, 4'b0001, seg_of(9), 3);
        drive_a(1'b1, 4'b0001, seg_of(6), 3);
        drive_a(1'b1, 4'b1000, seg_of(5), 3);
        drive_a(1'b1, 4'b0100, seg_of(4), 3);
        drive_a(1'b1, 4'b0010, seg_of(3), 2);
        nchk++; if (fv_a != b) begin nerr++; $display("FAIL overwrite_early: frames %0d want 0", fv_a - b); end
        drive_a(1'b1, 4'b0010, seg_of(3), 1);
        nchk++; if (ifa.frame_valid !== 1'b1 || ifa.bcd_out !== 16'h5436) begin nerr++; $display("FAIL overwrite_frame: fv %b bcd %h want 1/5436", ifa.frame_valid, ifa.bcd_out); end
    endtask

    task automatic test_mid_reset();
        int b;
        b = fv_a;
        scan_upper(1, 2, 3);
        rst_a_n = 1'b0;
        ifa.sample_en = 1'b0;
        tick();
        nchk++; if (ifa.bcd_out !== 16'h0000 || ifa.frame_valid !== 1'b0) begin nerr++; $display("FAIL midreset_clear: bcd %h fv %b want 0000/0", ifa.bcd_out, ifa.frame_valid); end
        rst_a_n = 1'b1;
        drive_a(1'b1, 4'b0001, seg_of(4), 3);
        nchk++; if (fv_a != b || ifa.bcd_out !== 16'h0000) begin nerr++; $display("FAIL midreset_partial: frames %0d bcd %h want 0/0000", fv_a - b, ifa.bcd_out); end
        scan_upper(1, 2, 3);
        nchk++; if (fv_a - b != 1 || ifa.bcd_out !== 16'h1234) begin nerr++; $display("FAIL midreset_refill: frames %0d bcd %h want 1/1234", fv_a - b, ifa.bcd_out); end
        drive_a(1'b0, 4'b0000, 7'd0, 1);
    endtask

    task automatic test_params();
        int b, e;
        for (int d = 0; d < 10; d++) begin
            drive_b(1'b1, 1'b1, seg_of(d));
            nchk++;
            if (ifb.frame_valid !== 1'b1 || ifb.bcd_out !== 4'(d) || ifb.blank_mask !== 1'b0) begin
                nerr++; $display("FAIL single_code_%0d: fv %b bcd %h blank %b want 1/%0d/0", d, ifb.frame_valid, ifb.bcd_out, ifb.blank_mask, d);
            end
        end
        drive_b(1'b1, 1'b1, SEG_BLANK);
        nchk++; if (ifb.frame_valid !== 1'b1 || ifb.bcd_out !== 4'hF || ifb.blank_mask !== 1'b1) begin nerr++; $display("FAIL single_blank: fv %b bcd %h blank %b want 1/f/1", ifb.frame_valid, ifb.bcd_out, ifb.blank_mask); end
        b = fv_b;
        drive_b(1'b1, 1'b1, SEG_BLANK);
        nchk++; if (fv_b != b) begin nerr++; $display("FAIL single_held: frames %0d want 0", fv_b - b); end
        e = err_b;
        drive_b(1'b1, 1'b1, SEG_ILL);
        nchk++; if (err_b - e != 1 || ifb.frame_valid !== 1'b0 || ifb.bcd_out !== 4'hF) begin nerr++; $display("FAIL single_illegal: errs %0d fv %b bcd %h want 1/0/f", err_b - e, ifb.frame_valid, ifb.bcd_out); end
        rst_b_n = 1'b0;
        ifb.sample_en = 1'b0;
        tick();
        rst_b_n = 1'b1;
        tick();
        nchk++; if (ifb.bcd_out !== 4'h0 || ifb.frame_valid !== 1'b0) begin nerr++; $display("FAIL single_reset: bcd %h fv %b want 0/0", ifb.bcd_out, ifb.frame_valid); end
        drive_b(1'b1, 1'b1, seg_of(8));
        nchk++; if (ifb.frame_valid !== 1'b1 || ifb.bcd_out !== 4'h8) begin nerr++; $display("FAIL single_after_reset: fv %b bcd %h want 1/8", ifb.frame_valid, ifb.bcd_out); end
        drive_b(1'b0, 1'b0, 7'd0);
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_blank_illegal();
        test_select_errors();
        test_hold_overwrite();
        test_mid_reset();
        test_params();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
